program_memory_arbiter: RTL and testbench

Owns the single port of the program memory (512 x 12 synchronous RAM) and shares it between CPU instruction fetch and an external program loader. In normal operation the CPU fetch address passes straight through. A load request holds the CPU in reset, streams words into memory with an auto-incrementing address, then releases the CPU so it restarts from address 0. Sits between the cpu core and program memory; replaces the tied-off data/wren connection.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/program_load_counter.sv | 46 ++++
 rtl/program_memory_arbiter.sv | 149 ++++++++++++++
 tb/tb_program_memory_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: program memory geometry and the program memory
// arbiter state encoding.
package cpu_pkg;

    localparam int PROG_ADDR_W = 9;
    localparam int PROG_DATA_W = 12;

    typedef enum logic [2:0] {
        ARB_RUN     = 3'd0,
        ARB_HALT    = 3'd1,
        ARB_LOAD    = 3'd2,
        ARB_RELEASE = 3'd3,
        ARB_FAULT   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/program_load_counter.sv
// Write-address and word counter for a program load session; flags when the
// current write address is the last location of program memory.
module program_load_counter
    import cpu_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W:0]   words_loaded_o,
    output logic              full_o
);

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]   words_q, words_d;

    always_comb begin
        wr_addr_d = wr_addr_q;
        words_d   = words_q;
        if (clear_i) begin
            wr_addr_d = '0;
            words_d   = '0;
        end else if (inc_i) begin
            wr_addr_d = wr_addr_q + 1'b1;
            words_d   = words_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            words_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            words_q   <= words_d;
        end
    end

    assign wr_addr_o      = wr_addr_q;
    assign words_loaded_o = words_q;
    assign full_o         = &wr_addr_q;

endmodule

// File: rtl/program_memory_arbiter.sv
// Shares the program memory port between CPU fetch and the program loader.
// Define CHECKSUM_EN to add end-of-load checksum verification and a FAULT state.
module program_memory_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = PROG_ADDR_W,
    parameter int DATA_W         = PROG_DATA_W,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
`ifdef CHECKSUM_EN
    input  logic [DATA_W-1:0] ld_checksum,
    output logic              cksum_err,
`endif
    output logic              ld_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              busy,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [3:0] REL_LOAD = 4'(RELEASE_CYCLES - 1);

    arb_state_e        state_q;
    logic [3:0]        rel_cnt_q;
    logic              hold_q, busy_q, ready_q;
    logic              accept, end_evt, full;
    logic [ADDR_W-1:0] wr_addr;

    assign accept  = ld_valid && ready_q;
    assign end_evt = accept && (ld_last || full);

    program_load_counter #(.ADDR_W(ADDR_W)) u_cnt (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (state_q == ARB_HALT),
        .inc_i          (accept),
        .wr_addr_o      (wr_addr),
        .words_loaded_o (words_loaded),
        .full_o         (full)
    );

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic              err_q;
    logic [DATA_W-1:0] sum_next;
    assign sum_next  = sum_q + ld_data;
    assign cksum_err = err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_RUN;
            rel_cnt_q <= '0;
            hold_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef CHECKSUM_EN
            sum_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ARB_RUN: begin
                    if (ld_start) begin
                        state_q <= ARB_HALT;
                        hold_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ARB_HALT: begin
                    state_q <= ARB_LOAD;
                    ready_q <= 1'b1;
`ifdef CHECKSUM_EN
                    sum_q   <= '0;
`endif
                end
                ARB_LOAD: begin
`ifdef CHECKSUM_EN
                    if (accept)
                        sum_q <= sum_next;
                    if (end_evt && (sum_next != ld_checksum)) begin
                        state_q <= ARB_FAULT;
                        ready_q <= 1'b0;
                        err_q   <= 1'b1;
                    end else
`endif
                    if (end_evt) begin
                        state_q   <= ARB_RELEASE;
                        ready_q   <= 1'b0;
                        rel_cnt_q <= REL_LOAD;
                    end
                end
                ARB_RELEASE: begin
                    if (rel_cnt_q == '0) begin
                        state_q <= ARB_RUN;
                        hold_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        rel_cnt_q <= rel_cnt_q - 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                ARB_FAULT: begin
                    if (ld_start) begin
                        state_q <= ARB_HALT;
                        err_q   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ARB_RUN;
                    hold_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // RELEASE presents address 0 so the restarting CPU finds its first word pre-read.
    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        case (state_q)
            ARB_RUN:  mem_address = cpu_address;
            ARB_LOAD: begin
                mem_address = wr_addr;
                mem_data    = ld_data;
                mem_wren    = accept;
            end
            default:  mem_address = '0;
        endcase
    end

    assign ld_ready = ready_q;
    assign cpu_hold = hold_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Self-checking bench for program_memory_arbiter; exercises the checksum path
// as well when CHECKSUM_EN is defined.
module tb_program_memory_arbiter;
    import cpu_pkg::*;

    localparam int AW = PROG_ADDR_W;
    localparam int DW = PROG_DATA_W;
    localparam int RC = 2;
    localparam int MEM_WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_address;
    logic          ld_start, ld_valid, ld_last;
    logic [DW-1:0] ld_data;
    logic          ld_ready, mem_wren, cpu_hold, busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [AW:0]   words_loaded;
`ifdef CHECKSUM_EN
    logic [DW-1:0] ld_checksum;
    logic          cksum_err;
`endif

    program_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RELEASE_CYCLES(RC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_address  (cpu_address),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
`ifdef CHECKSUM_EN
        .ld_checksum  (ld_checksum),
        .cksum_err    (cksum_err),
`endif
        .ld_ready     (ld_ready),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wren     (mem_wren),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          vld;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[4];

    logic          s_vld [0:699];
    logic          s_lst [0:699];
    logic          s_st  [0:699];
    logic [DW-1:0] s_dat [0:699];
    int            s_len;

    // Reference: a word is written at the running accepted count whenever valid is
    // high; the session ends on an accepted word carrying last or filling memory.
    task automatic run_session(input string tag);
        int          acc;
        bit          ended;
        logic [DW-1:0] sum;
        acc   = 0;
        ended = 0;
        sum   = '0;
        ld_start    = 1'b1;
        ld_valid    = 1'($urandom);
        cpu_address = AW'($urandom);
        #4;
        chk({tag, "_start_hold"}, 32'(cpu_hold), 32'd0);
        next_cycle();
        ld_start = 1'b0;
        #4;
        chk({tag, "_halt_hold"},  32'(cpu_hold), 32'd1);
        chk({tag, "_halt_ready"}, 32'(ld_ready), 32'd0);
        chk({tag, "_halt_wren"},  32'(mem_wren), 32'd0);
        next_cycle();
        for (int i = 0; i < s_len && !ended; i++) begin
            ld_valid    = s_vld[i];
            ld_data     = s_dat[i];
            ld_last     = s_lst[i];
            ld_start    = s_st[i];
            cpu_address = AW'($urandom);
`ifdef CHECKSUM_EN
            ld_checksum = sum + s_dat[i];
`endif
            #4;
            chk({tag, "_load_ready"}, 32'(ld_ready), 32'd1);
            chk({tag, "_load_hold"},  32'(cpu_hold), 32'd1);
            chk({tag, "_load_wren"},  32'(mem_wren), 32'(s_vld[i]));
            chk({tag, "_load_words"}, 32'(words_loaded), 32'(acc));
            if (s_vld[i]) begin
                chk({tag, "_wr_addr"}, 32'(mem_address), 32'(acc));
                chk({tag, "_wr_data"}, 32'(mem_data), 32'(s_dat[i]));
                sum = sum + s_dat[i];
                acc++;
                if (s_lst[i] || acc == MEM_WORDS) ended = 1;
            end
            next_cycle();
        end
        if (!ended) begin
            checks++;
            failures++;
            $display("FAIL %s_no_end_event accepted=%0d", tag, acc);
        end
        ld_start = 1'b0;
        for (int j = 0; j < RC; j++) begin
            ld_valid    = 1'b1;
            ld_last     = 1'($urandom);
            ld_data     = DW'($urandom);
            ld_start    = 1'($urandom);
            #4;
            chk({tag, "_rel_hold"},  32'(cpu_hold), 32'd1);
            chk({tag, "_rel_busy"},  32'(busy), 32'd1);
            chk({tag, "_rel_ready"}, 32'(ld_ready), 32'd0);
            chk({tag, "_rel_wren"},  32'(mem_wren), 32'd0);
            chk({tag, "_rel_addr"},  32'(mem_address), 32'd0);
            chk({tag, "_rel_data"},  32'(mem_data), 32'd0);
`ifdef CHECKSUM_EN
            chk({tag, "_rel_cksum_err"}, 32'(cksum_err), 32'd0);
`endif
            next_cycle();
        end
        ld_start    = 1'b0;
        ld_valid    = 1'b0;
        ld_last     = 1'b0;
        cpu_address = AW'($urandom);
        #4;
        chk({tag, "_run_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_run_busy"},  32'(busy), 32'd0);
        chk({tag, "_run_addr"},  32'(mem_address), 32'(cpu_address));
        chk({tag, "_run_words"}, 32'(words_loaded), 32'(acc));
        next_cycle();
    endtask

    task automatic clear_stream();
        for (int i = 0; i < 700; i++) begin
            s_vld[i] = 1'b0;
            s_lst[i] = 1'b0;
            s_st[i]  = 1'b0;
            s_dat[i] = '0;
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_address = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = '0;
`ifdef CHECKSUM_EN
        ld_checksum = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        #4;
        chk("reset_hold",  32'(cpu_hold), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_ready", 32'(ld_ready), 32'd0);
        chk("reset_wren",  32'(mem_wren), 32'd0);
        chk("reset_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        next_cycle();

        vecs[0] = '{9'h005, 1'b0, 9'h005};
        vecs[1] = '{9'h1A0, 1'b0, 9'h1A0};
        vecs[2] = '{9'h1FF, 1'b1, 9'h1FF};
        vecs[3] = '{9'h000, 1'b1, 9'h000};
        for (int v = 0; v < 4; v++) begin
            cpu_address = vecs[v].addr;
            ld_valid    = vecs[v].vld;
            ld_data     = DW'($urandom);
            #4;
            chk("pass_addr",  32'(mem_address), 32'(vecs[v].exp_addr));
            chk("pass_wren",  32'(mem_wren), 32'd0);
            chk("pass_hold",  32'(cpu_hold), 32'd0);
            chk("pass_ready", 32'(ld_ready), 32'd0);
            chk("pass_data",  32'(mem_data), 32'd0);
            next_cycle();
        end
        ld_valid = 1'b0;

        clear_stream();
        s_len = 3;
        s_vld[0] = 1; s_dat[0] = 12'hA01;
        s_vld[1] = 1; s_dat[1] = 12'h0C2;
        s_vld[2] = 1; s_dat[2] = 12'hFFF; s_lst[2] = 1;
        run_session("basic");

        clear_stream();
        s_len = 4;
        s_vld[0] = 1; s_dat[0] = 12'h111;
        s_dat[1] = 12'h222; s_lst[1] = 1;
        s_dat[2] = 12'h333;
        s_vld[3] = 1; s_dat[3] = 12'h444; s_lst[3] = 1;
        run_session("gaps");

        clear_stream();
        s_len = 600;
        for (int i = 0; i < 600; i++) begin
            s_vld[i] = 1;
            s_dat[i] = DW'($urandom);
        end
        run_session("full");

        clear_stream();
        s_len = 6;
        for (int i = 0; i < 6; i++) begin
            s_vld[i] = 1'(i != 2);
            s_dat[i] = DW'($urandom);
            s_st[i]  = 1'(i == 1 || i == 3);
        end
        s_lst[5] = 1;
        run_session("ign_start");

        for (int k = 0; k < 8; k++) begin
            clear_stream();
            s_len = $urandom_range(1, 40);
            for (int i = 0; i < s_len; i++) begin
                s_vld[i] = 1'($urandom_range(0, 2) != 0);
                s_dat[i] = DW'($urandom);
                s_lst[i] = 1'(!s_vld[i] && ($urandom_range(0, 3) == 0));
                s_st[i]  = 1'($urandom_range(0, 7) == 0);
            end
            s_vld[s_len-1] = 1;
            s_lst[s_len-1] = 1;
            run_session("rand");
        end

        ld_start = 1'b1;
        next_cycle();
        ld_start = 1'b0;
        next_cycle();
        ld_valid = 1'b1;
        ld_data  = 12'h5A5;
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b1;
        #2;
        chk("abort_hold",  32'(cpu_hold), 32'd0);
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_ready", 32'(ld_ready), 32'd0);
        chk("abort_wren",  32'(mem_wren), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd0);
        ld_valid = 1'b0;
        next_cycle();
        rst = 1'b0;
        cpu_address = 9'h0AB;
        #4;
        chk("abort_run_addr", 32'(mem_address), 32'h0AB);
        next_cycle();

        clear_stream();
        s_len = 2;
        s_vld[0] = 1; s_dat[0] = 12'h800;
        s_vld[1] = 1; s_dat[1] = 12'h801; s_lst[1] = 1;
        run_session("after_abort");

`ifdef CHECKSUM_EN
        ld_start = 1'b1;
        next_cycle();
        ld_start = 1'b0;
        next_cycle();
        ld_valid = 1'b1; ld_data = 12'h800; ld_last = 1'b0; ld_checksum = 12'h002;
        next_cycle();
        ld_data = 12'h801; ld_last = 1'b1; ld_checksum = 12'h002;
        next_cycle();
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int j = 0; j < RC + 3; j++) begin
            #4;
            chk("fault_err",   32'(cksum_err), 32'd1);
            chk("fault_hold",  32'(cpu_hold), 32'd1);
            chk("fault_busy",  32'(busy), 32'd1);
            chk("fault_ready", 32'(ld_ready), 32'd0);
            next_cycle();
        end
        ld_start = 1'b1;
        next_cycle();
        ld_start = 1'b0;
        #4;
        chk("fault_clear_err",  32'(cksum_err), 32'd0);
        chk("fault_clear_hold", 32'(cpu_hold), 32'd1);
        next_cycle();
        ld_valid = 1'b1; ld_data = 12'h123; ld_last = 1'b1; ld_checksum = 12'h123;
        next_cycle();
        ld_valid = 1'b0; ld_last = 1'b0;
        repeat (RC) next_cycle();
        #4;
        chk("fault_recover_hold",  32'(cpu_hold), 32'd0);
        chk("fault_recover_words", 32'(words_loaded), 32'd1);
        next_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
